pu_msp430_mac_sequencer: RTL and testbench

- Peripheral-bus initiator that drives the hardware multiplier's register interface on behalf of a streaming requester, such as a DSP accelerator or DMA.
- Accepts one command per handshake: operands, mode, and an optional accumulator clear.
- Issues the OP1/OP2 writes, waits for the product, reads RESLO/RESHI and returns a 32-bit result on a valid/ready response channel.
- Sits between the requester and the peripheral bus mux, in parallel with the CPU's peripheral master port.

---
 rtl/pu_msp430_mac_sequencer_pkg.sv | 28 ++
 rtl/pu_msp430_mac_sequencer_per_access.sv | 60 ++++++
 rtl/pu_msp430_mac_sequencer.sv | 149 ++++++++++++++
 tb/tb_pu_msp430_mac_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_msp430_mac_sequencer_pkg.sv
// Shared types and register map for the MSP430 multiplier sequencer.
package pu_msp430_mac_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CLR_LO, ST_CLR_HI, ST_WR_OP1, ST_WR_OP2,
    ST_WAIT, ST_RD_LO, ST_RD_HI, ST_RD_EXT, ST_RESP
  } state_e;

  typedef enum logic [1:0] {MODE_MPY, MODE_MPYS, MODE_MAC, MODE_MACS} mode_e;

  localparam logic [2:0] OFF_OP1_MPY  = 3'd0;
  localparam logic [2:0] OFF_OP1_MPYS = 3'd1;
  localparam logic [2:0] OFF_OP1_MAC  = 3'd2;
  localparam logic [2:0] OFF_OP1_MACS = 3'd3;
  localparam logic [2:0] OFF_OP2      = 3'd4;
  localparam logic [2:0] OFF_RESLO    = 3'd5;
  localparam logic [2:0] OFF_RESHI    = 3'd6;
  localparam logic [2:0] OFF_SUMEXT   = 3'd7;

  localparam logic [1:0] ACC_WR = 2'b11;
  localparam logic [1:0] ACC_RD = 2'b00;

  // The four OP1 aliases are laid out in mode order, so the mode selects the alias.
  function automatic logic [2:0] op1_offset(input mode_e m);
    return OFF_OP1_MPY + {1'b0, m};
  endfunction

endpackage

// File: rtl/pu_msp430_mac_sequencer_per_access.sv
// Peripheral bus driver: maps one access request to per_* and captures read data.
// MAC_SEQ_SUMEXT_EN enables capture of the SUMEXT readback.
module pu_msp430_per_access
  import pu_msp430_mac_seq_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0130
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        acc_en_i,
  input  logic [1:0]  acc_type_i,
  input  logic [2:0]  acc_off_i,
  input  logic [15:0] acc_data_i,
  output logic [13:0] per_addr_o,
  output logic [15:0] per_din_o,
  output logic        per_en_o,
  output logic [1:0]  per_we_o,
  input  logic [15:0] per_dout_i,
  output logic [15:0] res_lo_o,
  output logic [15:0] res_hi_o,
  output logic [15:0] sumext_o
);

  logic        rd;
  logic [15:0] res_lo_q;
  logic [15:0] res_hi_q;

  assign rd         = acc_en_i && (acc_type_i == ACC_RD);
  assign per_en_o   = acc_en_i;
  assign per_we_o   = acc_en_i ? acc_type_i : 2'b00;
  assign per_addr_o = acc_en_i ? (BASE_ADDR[14:1] + 14'(acc_off_i)) : 14'h0;
  assign per_din_o  = (acc_en_i && (acc_type_i == ACC_WR)) ? acc_data_i : 16'h0;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      if (rd && (acc_off_i == OFF_RESLO)) res_lo_q <= per_dout_i;
      if (rd && (acc_off_i == OFF_RESHI)) res_hi_q <= per_dout_i;
    end
  end

  assign res_lo_o = res_lo_q;
  assign res_hi_o = res_hi_q;

`ifdef MAC_SEQ_SUMEXT_EN
  logic [15:0] sumext_q;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n)                             sumext_q <= '0;
    else if (rd && (acc_off_i == OFF_SUMEXT))   sumext_q <= per_dout_i;
  end

  assign sumext_o = sumext_q;
`else
  assign sumext_o = 16'h0000;
`endif

endmodule

// File: rtl/pu_msp430_mac_sequencer.sv
// Bus initiator that runs one multiply/accumulate on the MSP430 hardware multiplier per command.
// MAC_SEQ_SUMEXT_EN adds a SUMEXT readback state before the response.
//
// state     | meaning
// IDLE      | ready for a command
// CLR_LO/HI | zero RESLO / RESHI (MAC/MACS with clear)
// WR_OP1    | write op1 to the mode-specific OP1 alias
// WR_OP2    | write op2, starts the multiply
// WAIT      | WAIT_CYC idle cycles for the product to settle
// RD_LO/HI  | read RESLO / RESHI
// RD_EXT    | read SUMEXT (feature builds only)
// RESP      | hold result until rsp_ready
module pu_msp430_mac_sequencer
  import pu_msp430_mac_seq_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0130,
  parameter int unsigned WAIT_CYC  = 1
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_mode,
  input  logic        cmd_clr_acc,
  input  logic [15:0] cmd_op1,
  input  logic [15:0] cmd_op2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [15:0] rsp_sumext,
  output logic        busy,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_we,
  input  logic [15:0] per_dout
);

  localparam logic [2:0] WAIT_LD = (WAIT_CYC == 0) ? 3'd0 : 3'(WAIT_CYC - 1);

  state_e      state_q, state_d;
  mode_e       mode_q;
  logic [15:0] op1_q, op2_q;
  logic [2:0]  cnt_q, cnt_d;
  logic        rdy_q;
  logic        accept;

  logic        acc_en;
  logic [1:0]  acc_type;
  logic [2:0]  acc_off;
  logic [15:0] acc_data;
  logic [15:0] res_lo, res_hi;

  assign accept = cmd_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = (cmd_clr_acc && cmd_mode[1]) ? ST_CLR_LO : ST_WR_OP1;
      ST_CLR_LO: state_d = ST_CLR_HI;
      ST_CLR_HI: state_d = ST_WR_OP1;
      ST_WR_OP1: state_d = ST_WR_OP2;
      ST_WR_OP2: begin
        if (WAIT_CYC == 0) begin
          state_d = ST_RD_LO;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_RD_LO;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_RD_LO:  state_d = ST_RD_HI;
`ifdef MAC_SEQ_SUMEXT_EN
      ST_RD_HI:  state_d = ST_RD_EXT;
      ST_RD_EXT: state_d = ST_RESP;
`else
      ST_RD_HI:  state_d = ST_RESP;
`endif
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MPY;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == ST_IDLE);
      if (accept) begin
        mode_q <= mode_e'(cmd_mode);
        op1_q  <= cmd_op1;
        op2_q  <= cmd_op2;
      end
    end
  end

  always_comb begin
    acc_en   = 1'b0;
    acc_type = ACC_RD;
    acc_off  = OFF_OP2;
    acc_data = 16'h0;
    case (state_q)
      ST_CLR_LO: begin acc_en = 1'b1; acc_type = ACC_WR; acc_off = OFF_RESLO; end
      ST_CLR_HI: begin acc_en = 1'b1; acc_type = ACC_WR; acc_off = OFF_RESHI; end
      ST_WR_OP1: begin acc_en = 1'b1; acc_type = ACC_WR; acc_off = op1_offset(mode_q); acc_data = op1_q; end
      ST_WR_OP2: begin acc_en = 1'b1; acc_type = ACC_WR; acc_off = OFF_OP2; acc_data = op2_q; end
      ST_RD_LO:  begin acc_en = 1'b1; acc_off = OFF_RESLO; end
      ST_RD_HI:  begin acc_en = 1'b1; acc_off = OFF_RESHI; end
`ifdef MAC_SEQ_SUMEXT_EN
      ST_RD_EXT: begin acc_en = 1'b1; acc_off = OFF_SUMEXT; end
`endif
      default:   acc_en = 1'b0;
    endcase
  end

  pu_msp430_per_access #(.BASE_ADDR(BASE_ADDR)) u_per_access (
    .mclk       (mclk),
    .puc_rst_n  (puc_rst_n),
    .acc_en_i   (acc_en),
    .acc_type_i (acc_type),
    .acc_off_i  (acc_off),
    .acc_data_i (acc_data),
    .per_addr_o (per_addr),
    .per_din_o  (per_din),
    .per_en_o   (per_en),
    .per_we_o   (per_we),
    .per_dout_i (per_dout),
    .res_lo_o   (res_lo),
    .res_hi_o   (res_hi),
    .sumext_o   (rsp_sumext)
  );

  assign cmd_ready  = rdy_q;
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = {res_hi, res_lo};

endmodule

// File: tb/tb_pu_msp430_mac_sequencer.sv
// Directed bench for pu_msp430_mac_sequencer with a behavioural multiplier on the peripheral bus.
module tb_pu_msp430_mac_sequencer;

`ifdef MAC_SEQ_SUMEXT_EN
  localparam int EXT = 1;
`else
  localparam int EXT = 0;
`endif

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic        cmd_valid, cmd_ready, cmd_clr_acc;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_op1, cmd_op2;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [15:0] rsp_sumext;
  logic        busy;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct packed {
    int          cyc;
    logic [13:0] addr;
    logic [1:0]  we;
    logic [15:0] din;
  } acc_t;
  acc_t trace[$];

  pu_msp430_mac_sequencer dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_clr_acc(cmd_clr_acc), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_sumext(rsp_sumext), .busy(busy),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en),
    .per_we(per_we), .per_dout(per_dout)
  );

  always #5 mclk = ~mclk;

  // Behavioural hardware multiplier at word address 0x098
  logic [15:0] m_op1 = 16'h0;
  logic [1:0]  m_mode = 2'd0;
  logic [31:0] m_res = 32'h0;
  logic [15:0] m_ext = 16'h0;
  logic [31:0] p_u, p_s;
  logic [32:0] s_u;
  logic [31:0] s_s;

  assign p_u = {16'h0, m_op1} * {16'h0, per_din};
  assign p_s = $signed({{16{m_op1[15]}}, m_op1}) * $signed({{16{per_din[15]}}, per_din});
  assign s_u = {1'b0, m_res} + {1'b0, p_u};
  assign s_s = m_res + p_s;

  always @(posedge mclk) begin
    if (per_en && per_we == 2'b11) begin
      case (per_addr)
        14'h098: begin m_op1 <= per_din; m_mode <= 2'd0; end
        14'h099: begin m_op1 <= per_din; m_mode <= 2'd1; end
        14'h09A: begin m_op1 <= per_din; m_mode <= 2'd2; end
        14'h09B: begin m_op1 <= per_din; m_mode <= 2'd3; end
        14'h09C: begin
          case (m_mode)
            2'd0: begin m_res <= p_u; m_ext <= 16'h0; end
            2'd1: begin m_res <= p_s; m_ext <= {16{p_s[31]}}; end
            2'd2: begin m_res <= s_u[31:0]; m_ext <= {15'h0, s_u[32]}; end
            default: begin m_res <= s_s; m_ext <= {16{s_s[31]}}; end
          endcase
        end
        14'h09D: m_res[15:0]  <= per_din;
        14'h09E: m_res[31:16] <= per_din;
        default: ;
      endcase
    end
  end

  always_comb begin
    per_dout = 16'h0;
    if (per_en && per_we == 2'b00) begin
      case (per_addr)
        14'h09D: per_dout = m_res[15:0];
        14'h09E: per_dout = m_res[31:16];
        14'h09F: per_dout = m_ext;
        default: per_dout = 16'h0;
      endcase
    end
  end

  always @(posedge mclk) begin
    if (per_en) trace.push_back('{cyc: cyc, addr: per_addr, we: per_we, din: per_din});
    cyc <= cyc + 1;
  end

  function automatic logic [15:0] sx(input logic [15:0] v);
`ifdef MAC_SEQ_SUMEXT_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk_acc(input string tag, input int idx, input int rel,
                         input logic [13:0] addr, input logic [1:0] we, input logic [15:0] din);
    logic [63:0] obs;
    obs = '1;
    if (idx < trace.size())
      obs = {16'(trace[idx].cyc - acc_cyc), 2'b00, trace[idx].addr, 14'h0, trace[idx].we, trace[idx].din};
    chk(tag, obs, {16'(rel), 2'b00, addr, 14'h0, we, din});
  endtask

  task automatic start_cmd(input logic [1:0] m, input logic c, input logic [15:0] a, input logic [15:0] b);
    cmd_mode = m; cmd_clr_acc = c; cmd_op1 = a; cmd_op2 = b;
    cmd_valid = 1'b1;
    trace.delete();
    acc_cyc = cyc;
    chk("cmd_ready_at_accept", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int lat, input logic [31:0] res, input logic [15:0] ext);
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) break;
      tick();
    end
    chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(lat));
    chk({tag, "_result"}, 64'(rsp_result), 64'(res));
    chk({tag, "_sumext"}, 64'(rsp_sumext), 64'(ext));
  endtask

  initial begin
    logic seen;
    puc_rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_mode = 2'd0; cmd_clr_acc = 1'b0; cmd_op1 = 16'h0; cmd_op2 = 16'h0;
    repeat (2) @(posedge mclk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_per_bus", {per_en, per_we, per_addr, per_din}, 64'd0);
    chk("rst_rsp_data", {rsp_result, rsp_sumext}, 64'd0);
    puc_rst_n = 1'b1;
    tick();
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // MPY 3*4
    start_cmd(2'd0, 1'b0, 16'h0003, 16'h0004);
    wait_rsp("mpy", 6 + EXT, 32'h0000000C, sx(16'h0000));
    chk("mpy_trace_len", 64'(trace.size()), 64'(4 + EXT));
    chk_acc("mpy_op1", 0, 1, 14'h098, 2'b11, 16'h0003);
    chk_acc("mpy_op2", 1, 2, 14'h09C, 2'b11, 16'h0004);
    chk_acc("mpy_rdlo", 2, 4, 14'h09D, 2'b00, 16'h0000);
    chk_acc("mpy_rdhi", 3, 5, 14'h09E, 2'b00, 16'h0000);
    chk("mpy_busy_in_resp", 64'(busy), 64'd1);
    tick();
    chk("mpy_idle_after", 64'(cmd_ready), 64'd1);

    // MPYS -1*2
    start_cmd(2'd1, 1'b0, 16'hFFFF, 16'h0002);
    wait_rsp("mpys", 6 + EXT, 32'hFFFFFFFE, sx(16'hFFFF));
    chk_acc("mpys_op1", 0, 1, 14'h099, 2'b11, 16'hFFFF);
    tick();

    // MAC with clear
    start_cmd(2'd2, 1'b1, 16'hFFFF, 16'hFFFF);
    wait_rsp("mac_clr", 8 + EXT, 32'hFFFE0001, sx(16'h0000));
    chk_acc("mac_clr_lo", 0, 1, 14'h09D, 2'b11, 16'h0000);
    chk_acc("mac_clr_hi", 1, 2, 14'h09E, 2'b11, 16'h0000);
    chk_acc("mac_op1", 2, 3, 14'h09A, 2'b11, 16'hFFFF);
    tick();

    // MAC accumulating onto the previous product
    start_cmd(2'd2, 1'b0, 16'hFFFF, 16'hFFFF);
    wait_rsp("mac_acc", 6 + EXT, 32'hFFFC0002, sx(16'h0001));
    tick();

    // MPY ignores clr_acc
    start_cmd(2'd0, 1'b1, 16'h0010, 16'h0010);
    wait_rsp("mpy_clr", 6 + EXT, 32'h00000100, sx(16'h0000));
    chk("mpy_clr_trace_len", 64'(trace.size()), 64'(4 + EXT));
    chk_acc("mpy_clr_first", 0, 1, 14'h098, 2'b11, 16'h0010);
    tick();

    // Backpressure
    rsp_ready = 1'b0;
    start_cmd(2'd0, 1'b0, 16'h0005, 16'h0007);
    wait_rsp("bp", 6 + EXT, 32'h00000023, sx(16'h0000));
    cmd_mode = 2'd0; cmd_clr_acc = 1'b0; cmd_op1 = 16'h0002; cmd_op2 = 16'h0003;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {rsp_valid, cmd_ready, per_en, rsp_result}, {1'b1, 1'b0, 1'b0, 32'h00000023});
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", {cmd_ready, rsp_valid}, {1'b1, 1'b0});
    acc_cyc = cyc;
    trace.delete();
    tick();
    cmd_valid = 1'b0;
    wait_rsp("bp_next", 6 + EXT, 32'h00000006, sx(16'h0000));
    tick();

    // Reset in WR_OP2
    start_cmd(2'd0, 1'b0, 16'h0009, 16'h0009);
    tick();
    chk("mid_wr_op2", {per_en, per_we, per_addr}, {1'b1, 2'b11, 14'h09C});
    puc_rst_n = 1'b0;
    #1;
    chk("mid_rst_bus", {per_en, per_we, per_addr, busy, rsp_valid}, 64'd0);
    tick();
    tick();
    puc_rst_n = 1'b1;
    tick();
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_rst_no_rsp", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
